pixel_downscaler: RTL and testbench
===================================

PIXEL_DOWNSCALER -- requirements
Module: pixel_downscaler

Interface
REQ-001 The module SHALL have parameter FRAME_WIDTH, default 10, meaning source frame width in pixels; it must be even and at least 2.
REQ-002 The module SHALL have parameter FRAME_HEIGHT, default 10, meaning source frame height in pixels; it must be even and at least 2.
REQ-003 The module SHALL have parameter DATA_WIDTH, default 8, meaning pixel width in bits.
REQ-004 The module SHALL have port clk_fpga, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset_fpga, input, 1 bit, a synchronous, active-high reset.
REQ-006 The module SHALL have port wen, input, 1 bit, pixel-valid strobe; a pixel is accepted on each edge where wen=1.
REQ-007 The module SHALL have port pixel, input, DATA_WIDTH bits, the source pixel, raster order, row-major.
REQ-008 The module SHALL have port dst_pixel, output, DATA_WIDTH bits, the downscaled pixel.
REQ-009 The module SHALL have port dst_valid, output, 1 bit, a one-cycle strobe qualifying dst_pixel and the dst coordinates.
REQ-010 The module SHALL have port dst_xcoord, output, 16 bits, the destination column, 0..FRAME_WIDTH/2-1.
REQ-011 The module SHALL have port dst_ycoord, output, 16 bits, the destination row, 0..FRAME_HEIGHT/2-1.
REQ-012 The module SHALL have port frame_done, output, 1 bit, asserted together with dst_valid for the last destination pixel of a frame.

Function
REQ-013 The module SHALL keep internal 16-bit source counters xcoord and ycoord; on each accepted pixel, xcoord increments, wrapping from FRAME_WIDTH-1 to 0, and on that wrap ycoord increments, wrapping from FRAME_HEIGHT-1 to 0.
REQ-014 The module SHALL track the row phase with a two-state FSM: ROW_EVEN (ycoord even) and ROW_ODD (ycoord odd); ROW_EVEN->ROW_ODD on wrap of xcoord, ROW_ODD->ROW_EVEN on wrap of xcoord.
REQ-015 The module SHALL, on an accepted pixel with xcoord even, hold the pixel in a horizontal pending register.
REQ-016 The module SHALL, in ROW_EVEN on an accepted pixel with xcoord odd, write pending+pixel (DATA_WIDTH+1 bits) to line-buffer entry xcoord/2.
REQ-017 The module SHALL, in ROW_ODD on an accepted pixel with xcoord odd, form sum = linebuf[xcoord/2] + pending + pixel in DATA_WIDTH+2 bits, without overflow.
REQ-018 The module SHALL output dst_pixel = sum >> 2, i.e. the floored 2x2 mean, registered with latency 1: it is valid on the edge after the completing pixel is accepted.
REQ-019 The module SHALL drive dst_xcoord = xcoord/2 and dst_ycoord = ycoord/2 of the completing pixel, registered alongside dst_pixel.
REQ-020 The module SHALL assert dst_valid for exactly one cycle per completed 2x2 block, giving FRAME_WIDTH*FRAME_HEIGHT/4 strobes per frame.
REQ-021 The module SHALL assert frame_done with dst_valid only for block (FRAME_WIDTH/2-1, FRAME_HEIGHT/2-1).
REQ-022 The module SHALL freeze counters, FSM, pending register and line buffer while wen=0; gaps of any length are legal anywhere, and dst_valid is 0 during gap cycles unless it is the latency-1 result.
REQ-023 The module SHALL treat the pixel after the frame's last pixel as source (0,0) of the next frame with no idle cycle required; back-to-back frames SHALL be supported.
REQ-024 The module SHALL drive dst_pixel, dst_xcoord and dst_ycoord to hold their last values when dst_valid=0.

Reset
REQ-025 The module SHALL, on reset_fpga=1 at a clock edge, clear xcoord, ycoord, pending, dst_pixel, dst_xcoord, dst_ycoord, dst_valid and frame_done to 0, and set the FSM to ROW_EVEN.
REQ-026 The module SHALL treat reset as dominant over wen, and SHALL treat the first pixel accepted after reset deasserts as source (0,0).
REQ-027 The module SHALL NOT reset the line-buffer contents; a line-buffer entry is always written in ROW_EVEN before it is read.
REQ-028 The module SHALL, on reset mid-frame, discard the partial frame, and no dst_valid from the discarded frame SHALL appear after reset.

Structure
REQ-029 The shared package face_detect_pkg SHALL hold BYTE_WIDTH=8, BYTE_DOUBLE_WIDTH=16, FRAME_WIDTH, FRAME_HEIGHT, FRAME_DST_WIDTH and FRAME_DST_HEIGHT, plus the row-phase enum {ROW_EVEN, ROW_ODD}.
REQ-030 The line buffer SHALL be one sub-module, downscale_line_buffer: FRAME_WIDTH/2 entries of DATA_WIDTH+1 bits, one write port, one combinational read port.

Verification
REQ-031 The bench SHALL drive a constant pixel of 100, continuous wen, one frame -> 25 dst_valid strobes, all dst_pixel=100, and frame_done only at (4,4).
REQ-032 The bench SHALL drive the ramp pixel=index 0..99 -> (0,0)=5 (0+1+10+11=22), (4,4)=93 (88+89+98+99=374), with dst_valid on the edge after the index-11 pixel is accepted.
REQ-033 The bench SHALL drive all pixels 255 -> every dst_pixel=255, with no overflow.
REQ-034 The bench SHALL repeat the ramp with wen=0 for 3 cycles after every pixel -> dst values and order identical to REQ-032, with 25 strobes.
REQ-035 The bench SHALL assert reset_fpga after 47 ramp pixels, then restart the ramp -> no stale strobe, and first output (0,0)=5.
REQ-036 The bench SHALL drive two back-to-back frames, the 8-bit ramp wrapping at 255 -> 50 strobes, two frame_done pulses, and second-frame (0,0)=(100+101+110+111)>>2=105.

Source files
------------

// File: rtl/face_detect_pkg.sv
// Shared constants and types for the face-detect front end.
// Frame geometry here is the default source frame fed to the downscaler.
package face_detect_pkg;

    localparam int BYTE_WIDTH        = 8;
    localparam int BYTE_DOUBLE_WIDTH = 16;
    localparam int FRAME_WIDTH       = 10;
    localparam int FRAME_HEIGHT      = 10;
    localparam int FRAME_DST_WIDTH   = FRAME_WIDTH / 2;
    localparam int FRAME_DST_HEIGHT  = FRAME_HEIGHT / 2;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_phase_e;

endpackage

// File: rtl/downscale_line_buffer.sv
// One line of horizontal pair sums, written on even source rows and
// read combinationally on odd rows. Contents are deliberately not reset.
module downscale_line_buffer #(
    parameter int DEPTH = 5,
    parameter int DW    = 9,
    parameter int AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pixel_downscaler.sv
// 2x2 box-filter downscaler: raster pixels in, floored 2x2 means out,
// one cycle after the pixel that completes each block.
module pixel_downscaler #(
    parameter int FRAME_WIDTH  = face_detect_pkg::FRAME_WIDTH,
    parameter int FRAME_HEIGHT = face_detect_pkg::FRAME_HEIGHT,
    parameter int DATA_WIDTH   = face_detect_pkg::BYTE_WIDTH
) (
    input  logic                  clk_fpga,
    input  logic                  reset_fpga,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] pixel,
    output logic [DATA_WIDTH-1:0] dst_pixel,
    output logic                  dst_valid,
    output logic [15:0]           dst_xcoord,
    output logic [15:0]           dst_ycoord,
    output logic                  frame_done
);

    localparam int          LB_DEPTH = FRAME_WIDTH / 2;
    localparam int          LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [15:0] X_LAST   = 16'(FRAME_WIDTH - 1);
    localparam logic [15:0] Y_LAST   = 16'(FRAME_HEIGHT - 1);

    face_detect_pkg::row_phase_e r_state, w_state_nxt;

    logic [15:0]           r_xcoord, r_ycoord;
    logic [DATA_WIDTH-1:0] r_pending;
    logic [DATA_WIDTH-1:0] r_dst_pixel;
    logic [15:0]           r_dst_xcoord, r_dst_ycoord;
    logic                  r_dst_valid, r_frame_done;

    logic                  w_x_wrap, w_y_wrap, w_x_odd, w_row_odd;
    logic                  w_lb_we, w_blk_done;
    logic [LB_AW-1:0]      w_lb_addr;
    logic [DATA_WIDTH:0]   w_lb_wdata, w_lb_rdata;
    logic [DATA_WIDTH+1:0] w_sum;

    assign w_x_wrap   = (r_xcoord == X_LAST);
    assign w_y_wrap   = (r_ycoord == Y_LAST);
    assign w_x_odd    = r_xcoord[0];
    assign w_lb_addr  = r_xcoord[LB_AW:1];
    assign w_lb_we    = wen & w_x_odd & ~w_row_odd & ~reset_fpga;
    assign w_blk_done = wen & w_x_odd & w_row_odd;

    // Sums are widened before adding so 4 x max never overflows.
    assign w_lb_wdata = {1'b0, r_pending} + {1'b0, pixel};
    assign w_sum      = {1'b0, w_lb_rdata} + {2'b00, r_pending} + {2'b00, pixel};

    // Row-phase FSM
    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) r_state <= face_detect_pkg::ROW_EVEN;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (wen && w_x_wrap) begin
            case (r_state)
                face_detect_pkg::ROW_EVEN: w_state_nxt = face_detect_pkg::ROW_ODD;
                face_detect_pkg::ROW_ODD:  w_state_nxt = face_detect_pkg::ROW_EVEN;
                default:                   w_state_nxt = face_detect_pkg::ROW_EVEN;
            endcase
        end
    end

    always_comb begin
        w_row_odd = (r_state == face_detect_pkg::ROW_ODD);
    end

    // Source raster position and horizontal pending pixel
    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            r_xcoord  <= '0;
            r_ycoord  <= '0;
            r_pending <= '0;
        end else if (wen) begin
            r_xcoord <= w_x_wrap ? 16'd0 : r_xcoord + 16'd1;
            if (w_x_wrap) r_ycoord <= w_y_wrap ? 16'd0 : r_ycoord + 16'd1;
            if (!w_x_odd) r_pending <= pixel;
        end
    end

    // Output stage; data and coords hold between strobes
    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            r_dst_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_dst_pixel  <= '0;
            r_dst_xcoord <= '0;
            r_dst_ycoord <= '0;
        end else begin
            r_dst_valid  <= w_blk_done;
            r_frame_done <= w_blk_done & w_x_wrap & w_y_wrap;
            if (w_blk_done) begin
                r_dst_pixel  <= w_sum[DATA_WIDTH+1:2];
                r_dst_xcoord <= {1'b0, r_xcoord[15:1]};
                r_dst_ycoord <= {1'b0, r_ycoord[15:1]};
            end
        end
    end

    downscale_line_buffer #(
        .DEPTH (LB_DEPTH),
        .DW    (DATA_WIDTH + 1),
        .AW    (LB_AW)
    ) u_line_buffer (
        .i_clk   (clk_fpga),
        .i_we    (w_lb_we),
        .i_waddr (w_lb_addr),
        .i_wdata (w_lb_wdata),
        .i_raddr (w_lb_addr),
        .o_rdata (w_lb_rdata)
    );

    assign dst_pixel  = r_dst_pixel;
    assign dst_valid  = r_dst_valid;
    assign dst_xcoord = r_dst_xcoord;
    assign dst_ycoord = r_dst_ycoord;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_downscaler.sv
// Bench for pixel_downscaler: directed and random frames checked against a
// frame-image model that averages each 2x2 block directly.
module tb_pixel_downscaler;

    localparam int W  = 10;
    localparam int H  = 10;
    localparam int DW = 8;

    logic          clk_fpga   = 1'b0;
    logic          reset_fpga = 1'b1;
    logic          wen        = 1'b0;
    logic [DW-1:0] pixel      = '0;
    logic [DW-1:0] dst_pixel;
    logic          dst_valid;
    logic [15:0]   dst_xcoord, dst_ycoord;
    logic          frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int strobes = 0;
    int dones   = 0;
    int fpos    = 0;
    int last_pix = 0;
    int img [H][W];

    always #5 clk_fpga = ~clk_fpga;

    pixel_downscaler #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk_fpga   (clk_fpga),
        .reset_fpga (reset_fpga),
        .wen        (wen),
        .pixel      (pixel),
        .dst_pixel  (dst_pixel),
        .dst_valid  (dst_valid),
        .dst_xcoord (dst_xcoord),
        .dst_ycoord (dst_ycoord),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept one pixel; outputs are sampled 1 time unit after the edge.
    task automatic send(input logic [DW-1:0] p);
        int x, y, mean;
        x = fpos % W;
        y = fpos / W;
        img[y][x] = int'(p);
        wen   = 1'b1;
        pixel = p;
        @(posedge clk_fpga);
        #1;
        wen = 1'b0;
        if ((x % 2 == 1) && (y % 2 == 1)) begin
            mean = (img[y-1][x-1] + img[y-1][x] + img[y][x-1] + img[y][x]) / 4;
            check("valid", 32'(dst_valid), 1);
            check("pixel", 32'(dst_pixel), mean);
            check("xcoord", 32'(dst_xcoord), x / 2);
            check("ycoord", 32'(dst_ycoord), y / 2);
            check("frame_done", 32'(frame_done), ((x == W-1) && (y == H-1)) ? 1 : 0);
            last_pix = mean;
        end else begin
            check("no_valid", 32'(dst_valid), 0);
            check("no_done", 32'(frame_done), 0);
        end
        if (dst_valid) strobes++;
        if (frame_done) dones++;
        fpos = (fpos + 1) % (W * H);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            wen   = 1'b0;
            pixel = 8'($urandom_range(255));
            @(posedge clk_fpga);
            #1;
            check("gap_valid", 32'(dst_valid), 0);
            check("gap_hold", 32'(dst_pixel), last_pix);
        end
    endtask

    // Reset is held with wen=1 to show reset dominates.
    task automatic do_reset();
        reset_fpga = 1'b1;
        wen        = 1'b1;
        pixel      = 8'($urandom_range(255));
        @(posedge clk_fpga);
        #1;
        check("rst_valid", 32'(dst_valid), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_pixel", 32'(dst_pixel), 0);
        check("rst_x", 32'(dst_xcoord), 0);
        check("rst_y", 32'(dst_ycoord), 0);
        reset_fpga = 1'b0;
        wen        = 1'b0;
        fpos       = 0;
        last_pix   = 0;
    endtask

    initial begin
        do_reset();
        gap(2);

        // Constant 100
        strobes = 0; dones = 0;
        for (int i = 0; i < W*H; i++) send(8'd100);
        check("const_strobes", strobes, 25);
        check("const_dones", dones, 1);

        // Ramp 0..99 with literal corner values
        strobes = 0; dones = 0;
        for (int i = 0; i < W*H; i++) begin
            send(8'(i));
            if (i == 11) check("ramp_00", 32'(dst_pixel), 5);
            if (i == 99) check("ramp_44", 32'(dst_pixel), 93);
        end
        check("ramp_strobes", strobes, 25);
        check("ramp_dones", dones, 1);

        // Saturated input
        strobes = 0;
        for (int i = 0; i < W*H; i++) send(8'd255);
        check("max_strobes", strobes, 25);
        check("max_last", 32'(dst_pixel), 255);

        // Ramp with 3-cycle gaps after every pixel
        strobes = 0; dones = 0;
        for (int i = 0; i < W*H; i++) begin
            send(8'(i));
            if (i == 11) check("gapramp_00", 32'(dst_pixel), 5);
            if (i == 99) check("gapramp_44", 32'(dst_pixel), 93);
            gap(3);
        end
        check("gapramp_strobes", strobes, 25);
        check("gapramp_dones", dones, 1);

        // Mid-frame reset after 47 pixels, then fresh ramp
        for (int i = 0; i < 47; i++) send(8'(i));
        do_reset();
        gap(3);
        strobes = 0; dones = 0;
        for (int i = 0; i < W*H; i++) begin
            send(8'(i));
            if (i == 11) check("rst_ramp_00", 32'(dst_pixel), 5);
        end
        check("rst_ramp_strobes", strobes, 25);

        // Two back-to-back frames, ramp wrapping at 255
        strobes = 0; dones = 0;
        for (int i = 0; i < 2*W*H; i++) begin
            send(8'(i % 256));
            if (i == 111) check("b2b_f2_00", 32'(dst_pixel), 105);
        end
        check("b2b_strobes", strobes, 50);
        check("b2b_dones", dones, 2);

        // Random pixels with random gaps, two frames
        strobes = 0; dones = 0;
        for (int i = 0; i < 2*W*H; i++) begin
            send(8'($urandom_range(255)));
            gap(int'($urandom_range(2)));
        end
        check("rand_strobes", strobes, 50);
        check("rand_dones", dones, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
